alu_seq_ctrl: RTL and testbench

- Multi-cycle 16-bit operation sequencer that drives the 8-bit combinational ALU from the controlling side.
- Accepts a 16-bit op request, then issues one 8-bit ALU operation per clock, chaining carries between byte halves.
- Registers each ALU result and returns a 16-bit result with flags.
- Sits between the core's multi-byte instruction path and the ALU instance.

---
 rtl/alu_seq_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: 16-bit ADD/SUB/LSL/XOR sequencer driving an external 8-bit
// combinational ALU, one byte operation per clock, carries chained by the
// sequencer. Optional signed-overflow flag output enabled by ALU_SEQ_OVF_EN.
module alu_seq_ctrl #(
   parameter int unsigned SHAMT_W = 4
) (
   input  logic               Clk,
   input  logic               Rst_n,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [15:0]        a,
   input  logic [15:0]        b,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               busy,
   output logic               done,
   output logic [15:0]        result,
   output logic               carry_out,
   output logic               zero,
   output logic [2:0]         alu_op,
   output logic [1:0]         alu_mode,
   output logic [7:0]         alu_a,
   output logic [7:0]         alu_b,
   output logic               alu_sci,
   output logic               alu_ci,
   output logic               alu_odd,
   input  logic [7:0]         alu_rslt,
   input  logic               alu_sco,
   input  logic               alu_co
`ifdef ALU_SEQ_OVF_EN
   ,
   output logic               ovf
`endif
);

   typedef enum logic [3:0] {
      S_IDLE, S_ADD_LO, S_ADD_HI, S_INV_LO, S_INV_HI,
      S_SHL_LO, S_SHL_HI, S_XOR_LO, S_XOR_HI, S_DONE
   } state_t;

   state_t             state;
   logic [15:0]        r;      // working result / operand A
   logic [15:0]        bb;     // working operand B (inverted in place for SUB)
   logic [SHAMT_W-1:0] cnt;    // remaining shift steps
   logic [1:0]         opr;    // latched opcode
   logic               cy;     // carry chained between bytes / final carry
   logic               sbit;   // bit shifted out of the low byte
`ifdef ALU_SEQ_OVF_EN
   logic               ovf_w;
`endif

   // ALU drive decoded from the current state and working registers
   always_comb begin
      alu_op   = 3'b010;
      alu_mode = 2'b00;
      alu_a    = 8'h00;
      alu_b    = 8'h00;
      alu_sci  = 1'b0;
      alu_ci   = 1'b0;
      alu_odd  = 1'b0;
      case (state)
         S_ADD_LO: begin
            alu_op = 3'b000;
            alu_a  = r[7:0];
            alu_b  = bb[7:0];
            alu_ci = (opr == 2'b01);   // +1 completes two's complement for SUB
         end
         S_ADD_HI: begin
            alu_op = 3'b000;
            alu_a  = r[15:8];
            alu_b  = bb[15:8];
            alu_ci = cy;
         end
         S_INV_LO: begin
            alu_op = 3'b001;
            alu_a  = bb[7:0];
            alu_b  = 8'hFF;
         end
         S_INV_HI: begin
            alu_op = 3'b001;
            alu_a  = bb[15:8];
            alu_b  = 8'hFF;
         end
         S_XOR_LO: begin
            alu_op = 3'b001;
            alu_a  = r[7:0];
            alu_b  = bb[7:0];
         end
         S_XOR_HI: begin
            alu_op = 3'b001;
            alu_a  = r[15:8];
            alu_b  = bb[15:8];
         end
         S_SHL_LO: begin
            alu_op = 3'b101;
            alu_a  = r[7:0];
         end
         S_SHL_HI: begin
            alu_op = 3'b101;
            alu_a  = r[15:8];
         end
         default: ;
      endcase
   end

   // sequencer FSM: accept, per-byte result capture, completion flags
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state     <= S_IDLE;
         r         <= '0;
         bb        <= '0;
         cnt       <= '0;
         opr       <= '0;
         cy        <= 1'b0;
         sbit      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         zero      <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
         ovf_w     <= 1'b0;
         ovf       <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               // busy still high here only during the done pulse; start ignored then
               if (busy) begin
                  busy <= 1'b0;
               end else if (start) begin
                  r    <= a;
                  bb   <= b;
                  cnt  <= shamt;
                  opr  <= op;
                  cy   <= 1'b0;
                  busy <= 1'b1;
`ifdef ALU_SEQ_OVF_EN
                  ovf_w <= 1'b0;
`endif
                  case (op)
                     2'b00:   state <= S_ADD_LO;
                     2'b01:   state <= S_INV_LO;
                     2'b10:   state <= (shamt == '0) ? S_DONE : S_SHL_LO;
                     default: state <= S_XOR_LO;
                  endcase
               end
            end
            S_ADD_LO: begin
               r[7:0] <= alu_rslt;
               cy     <= alu_co;
               state  <= S_ADD_HI;
            end
            S_ADD_HI: begin
               r[15:8] <= alu_rslt;
               cy      <= alu_co;
`ifdef ALU_SEQ_OVF_EN
               ovf_w   <= (r[15] == bb[15]) && (alu_rslt[7] != r[15]);
`endif
               state   <= S_DONE;
            end
            S_INV_LO: begin
               bb[7:0] <= alu_rslt;
               state   <= S_INV_HI;
            end
            S_INV_HI: begin
               bb[15:8] <= alu_rslt;
               state    <= S_ADD_LO;
            end
            S_XOR_LO: begin
               r[7:0] <= alu_rslt;
               state  <= S_XOR_HI;
            end
            S_XOR_HI: begin
               r[15:8] <= alu_rslt;
               cy      <= 1'b0;
               state   <= S_DONE;
            end
            S_SHL_LO: begin
               r[7:0] <= alu_rslt;
               sbit   <= alu_sco;
               state  <= S_SHL_HI;
            end
            S_SHL_HI: begin
               // ALU shifts a 0 into bit 0; the low byte's outgoing bit belongs there
               r[15:8] <= {alu_rslt[7:1], alu_rslt[0] | sbit};
               cy      <= alu_sco;
               cnt     <= cnt - 1'b1;
               state   <= (cnt == SHAMT_W'(1)) ? S_DONE : S_SHL_LO;
            end
            S_DONE: begin
               result    <= r;
               carry_out <= cy;
               zero      <= (r == '0);
               done      <= 1'b1;
`ifdef ALU_SEQ_OVF_EN
               ovf       <= ovf_w;
`endif
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed plus random checks of alu_seq_ctrl against a
// behavioural ALU and a plain-arithmetic 16-bit reference.
module tb_alu_seq_ctrl;

   logic        Clk;
   logic        Rst_n;
   logic        start;
   logic [1:0]  op;
   logic [15:0] a, b;
   logic [3:0]  shamt;
   logic        busy, done, carry_out, zero;
   logic [15:0] result;
   logic [2:0]  alu_op;
   logic [1:0]  alu_mode;
   logic [7:0]  alu_a, alu_b, alu_rslt;
   logic        alu_sci, alu_ci, alu_odd, alu_sco, alu_co;
`ifdef ALU_SEQ_OVF_EN
   logic        ovf;
`endif

   int unsigned total;
   int unsigned passed;
   int unsigned failed;

   alu_seq_ctrl #(.SHAMT_W(4)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .start(start), .op(op), .a(a), .b(b),
      .shamt(shamt), .busy(busy), .done(done), .result(result),
      .carry_out(carry_out), .zero(zero), .alu_op(alu_op),
      .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_sci(alu_sci), .alu_ci(alu_ci), .alu_odd(alu_odd),
      .alu_rslt(alu_rslt), .alu_sco(alu_sco), .alu_co(alu_co)
`ifdef ALU_SEQ_OVF_EN
      , .ovf(ovf)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // behavioural 8-bit ALU
   logic [8:0] sum9;
   always_comb begin
      sum9     = 9'(alu_a) + 9'(alu_b) + 9'(alu_sci) + 9'(alu_ci);
      alu_rslt = 8'h00;
      alu_co   = 1'b0;
      alu_sco  = 1'b0;
      case (alu_op)
         3'b000: {alu_co, alu_rslt} = sum9;
         3'b001: alu_rslt = alu_a ^ alu_b;
         3'b101: if (alu_mode == 2'b00) {alu_sco, alu_rslt} = {alu_a, 1'b0};
         default: ;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // one operation end to end; hammer keeps start high while busy
   task automatic run_op(input logic [1:0] o, input logic [15:0] av, input logic [15:0] bv,
                         input logic [3:0] sh, input bit hammer);
      logic [16:0] s;
      logic [31:0] t;
      logic [15:0] er;
      logic        ec, eo;
      int unsigned lat, n;
      eo = 1'b0;
      case (o)
         2'd0: begin
            s = {1'b0, av} + {1'b0, bv}; er = s[15:0]; ec = s[16]; lat = 3;
            eo = (av[15] == bv[15]) && (er[15] != av[15]);
         end
         2'd1: begin
            s = {1'b0, av} + {1'b0, ~bv} + 17'd1; er = s[15:0]; ec = s[16]; lat = 5;
            eo = (av[15] == ~bv[15]) && (er[15] != av[15]);
         end
         2'd2: begin
            t = 32'(av) << sh; er = t[15:0]; ec = (sh != 0) ? t[16] : 1'b0;
            lat = 2 * int'(sh) + 1;
         end
         default: begin
            er = av ^ bv; ec = 1'b0; lat = 3;
         end
      endcase
      @(negedge Clk);
      op = o; a = av; b = bv; shamt = sh; start = 1'b1;
      @(posedge Clk);
      #1;
      check("busy_at_accept", 32'(busy), 32'd1);
      start = hammer;
      a = 16'($urandom); b = 16'($urandom); shamt = 4'($urandom);
      op = 2'($urandom);
      n = 0;
      while (n < 40) begin
         @(posedge Clk);
         n++;
         #1;
         if (done) break;
      end
      start = 1'b0;
      check($sformatf("latency op%0d", o), n, lat);
      check($sformatf("result op%0d %h,%h,%0d", o, av, bv, sh), 32'(result), 32'(er));
      check($sformatf("carry op%0d", o), 32'(carry_out), 32'(ec));
      check($sformatf("zero op%0d", o), 32'(zero), 32'(er == 16'h0));
`ifdef ALU_SEQ_OVF_EN
      check($sformatf("ovf op%0d", o), 32'(ovf), 32'(eo));
`endif
      check("busy_in_done", 32'(busy), 32'd1);
      @(posedge Clk);
      #1;
      check("done_single_pulse", 32'(done), 32'd0);
      check("busy_fall", 32'(busy), 32'd0);
      check("alu_idle_op", 32'(alu_op), 32'd2);
      check("alu_odd", 32'(alu_odd), 32'd0);
   endtask

   initial begin
      total = 0; passed = 0; failed = 0;
      Rst_n = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0; shamt = '0;
      repeat (2) @(posedge Clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_carry", 32'(carry_out), 32'd0);
      check("rst_zero", 32'(zero), 32'd0);
      check("rst_alu_op", 32'(alu_op), 32'd2);
      check("rst_alu_a", 32'(alu_a), 32'd0);
      @(negedge Clk);
      Rst_n = 1'b1;

      run_op(2'd0, 16'h00FF, 16'h0001, 4'd0, 1'b0);
      run_op(2'd0, 16'hFFFF, 16'h0001, 4'd0, 1'b0);
      run_op(2'd0, 16'h7FFF, 16'h0001, 4'd0, 1'b0);
      run_op(2'd1, 16'h1234, 16'h0235, 4'd0, 1'b0);
      run_op(2'd1, 16'h0001, 16'h0002, 4'd0, 1'b0);
      run_op(2'd1, 16'h8000, 16'h0001, 4'd0, 1'b0);
      run_op(2'd2, 16'h8081, 16'h0000, 4'd1, 1'b0);
      run_op(2'd2, 16'h8081, 16'h0000, 4'd0, 1'b0);
      run_op(2'd2, 16'h0001, 16'h0000, 4'd15, 1'b0);
      run_op(2'd3, 16'hA5A5, 16'hFFFF, 4'd0, 1'b1);
      run_op(2'd1, 16'h5555, 16'h5555, 4'd0, 1'b1);

      // reset in the middle of a long shift
      @(negedge Clk);
      op = 2'd2; a = 16'h0001; shamt = 4'd15; start = 1'b1;
      @(posedge Clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge Clk);
      #2;
      Rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_result", 32'(result), 32'd0);
      check("midrst_alu_op", 32'(alu_op), 32'd2);
      check("midrst_done", 32'(done), 32'd0);
      @(negedge Clk);
      Rst_n = 1'b1;
      begin
         bit seen;
         seen = 1'b0;
         repeat (35) begin
            @(posedge Clk);
            #1;
            if (done) seen = 1'b1;
         end
         check("midrst_no_done", 32'(seen), 32'd0);
      end
      run_op(2'd0, 16'h1111, 16'h2222, 4'd0, 1'b0);

      for (int i = 0; i < 24; i++) begin
         run_op(2'($urandom), 16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
